hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Load-use hazard detection and pipeline stall/flush control for the 5-stage MIPS core.
//   Sits between the IF/ID and ID/EX registers, driving PC write, IF/ID write/flush and the ID control-zeroing mux.
//   Successor to the single-cycle load-use detector, adding:
//     - a parametrised stall length (multi-cycle memory);
//     - $zero exclusion;
//     - rt-source decode for SW/BEQ/BNE;
//     - branch-flush priority;
//     - saturating stall/flush statistics counters.
// PARAMETERS
//   REG_W         5    register-address width
//   OPC_W         6    opcode width
//   STALL_CYCLES  1    bubble cycles per load-use hazard; legal 1..15, elaboration $error otherwise
//   CNT_W         16   width of the statistics counters
// PORTS
//   clk             in   1      clock, all state on rising edge
//   rst             in   1      synchronous, active-high reset
//   idex_mem_read   in   1      instruction in ID/EX is a load
//   idex_rt         in   REG_W  load destination register (ID/EX rt)
//   ifid_rs         in   REG_W  rs of instruction in ID
//   ifid_rt         in   REG_W  rt of instruction in ID
//   ifid_opc        in   OPC_W  opcode of instruction in ID
//   branch_taken    in   1      branch/jump resolved taken this cycle; younger instrs must be squashed
//   pc_write        out  1      1 = PC updates
//   ifid_write      out  1      1 = IF/ID register loads
//   id_ctrl_en      out  1      1 = ID control signals pass; 0 = zeroed (bubble)
//   ifid_flush      out  1      1 = IF/ID register cleared to NOP on next edge
//   stall_count     out  CNT_W  cycles spent stalled, saturating
//   flush_count     out  CNT_W  flush events, saturating
// BEHAVIOUR
//   - rt_used = opc in {RTYPE, SW, BEQ, BNE}.
//   - detect  = idex_mem_read && idex_rt!=0 && (idex_rt==ifid_rs || (rt_used && idex_rt==ifid_rt)).
//   - FSM states RUN, STALL; 4-bit remaining counter rem.
//   - Control outputs are Mealy (combinational from state + inputs); a hazard stalls in the same cycle it is detected.
//   - Reset: while rst=1, outputs are forced regardless of inputs:
//       - pc_write=1, ifid_write=1, id_ctrl_en=1, ifid_flush=0;
//       - next state RUN, rem=0, both counters=0.
//     Reset mid-stall abandons the stall; the next cycle is RUN.
//   - RUN, branch_taken=1:
//       - outputs: ifid_flush=1, pc_write=1, ifid_write=1, id_ctrl_en=0;
//       - stay RUN; flush_count++;
//       - detect is ignored (flush beats stall).
//   - RUN, detect=1, branch_taken=0:
//       - outputs: pc_write=0, ifid_write=0, id_ctrl_en=0, ifid_flush=0;
//       - if STALL_CYCLES>1: go to STALL with rem=STALL_CYCLES-1; else stay RUN.
//   - RUN, neither: all pass (1,1,1,0).
//   - STALL, branch_taken=0:
//       - outputs: pc_write=0, ifid_write=0, id_ctrl_en=0, ifid_flush=0;
//       - rem--; when rem==1 this cycle, next state RUN;
//       - detect is ignored, since the load has left ID/EX.
//   - STALL, branch_taken=1:
//       - outputs and flush_count as in RUN flush;
//       - next RUN, rem cleared.
//   - Stall length: each hazard gives exactly STALL_CYCLES consecutive cycles with pc_write=0, then a pass cycle,
//     unless a flush or reset intervenes.
//   - A fresh detect in the cycle right after a stall ends is a new hazard and stalls again.
//   - stall_count increments on every non-reset cycle with pc_write=0; flush_count on every cycle with ifid_flush=1.
//   - Both counters saturate at all-ones; no wrap.
// STRUCTURE
//   - Package hazard_pkg holds:
//       - OPC_RTYPE=6'b000000, OPC_SW=6'b101011, OPC_BEQ=6'b000100, OPC_BNE=6'b000101;
//       - typedef enum logic {RUN, STALL} hz_state_t.
//   - Sub-module hazard_sat_counter #(W): inc, clk, rst -> count, saturating. Instantiated twice.
// TESTING
//   1. Load-use: mem_read=1, idex_rt=8, ifid_rs=8, opc=0, STALL_CYCLES=1 ->
//      (pc_write,ifid_write,id_ctrl_en)=000 for one cycle, then 111; stall_count=1.
//   2. $zero and I-type: idex_rt=0=ifid_rs -> no stall.
//      idex_rt=9=ifid_rt, opc=ADDI (001000) -> no stall.
//      Same with opc=SW -> stall.
//   3. STALL_CYCLES=3, hazard at cycle 10 -> pc_write=0 at cycles 10-12, 1 at 13; stall_count=3.
//   4. Flush priority: detect=1 and branch_taken=1 together -> ifid_flush=1, pc_write=1, id_ctrl_en=0, flush_count=1.
//      STALL_CYCLES=3 with branch_taken on the 2nd stall cycle -> RUN next cycle.
//   5. Reset mid-stall (STALL_CYCLES=4, rst at 2nd stall cycle) -> outputs 1110 that cycle, counters 0, RUN after.
//   6. Saturation: CNT_W=2, 5 hazards -> stall_count holds 3.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hazard_pkg
// Description : Shared opcodes and FSM state type for the load-use hazard /
//               stall / flush controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Opcodes whose rt field is a source operand (R-type ALU, store, branches)
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sat_counter
// Description : W-bit event counter that sticks at all-ones instead of
//               wrapping. Synchronous active-high clear.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count events; hold once every bit is set
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule : hazard_sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Load-use hazard detection and stall/flush control for the
//               5-stage MIPS pipeline. Drives PC write enable, IF/ID write
//               enable and flush, and the ID control-zeroing mux. A taken
//               branch always wins over a pending or new stall. Keeps
//               saturating statistics of stalled cycles and flush events.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int OPC_W        = 6,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [OPC_W-1:0] ifid_opc,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             id_ctrl_en,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The remaining-cycles counter is 4 bits, so only 1..15 bubbles fit
  generate
    if ((STALL_CYCLES < 1) || (STALL_CYCLES > 15)) begin : g_bad_stall_cycles
      $error("hazard_stall_ctrl: STALL_CYCLES must be in 1..15");
    end
  endgenerate

  // Cycles still to stall after the detecting cycle itself
  localparam logic [3:0] REM_LOAD = 4'(STALL_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [3:0] rem_q, rem_d;

  logic rt_used;
  logic detect;
  logic stall_inc;
  logic flush_inc;

  // rt is a source only for R-type, SW and the two compare branches
  assign rt_used = (ifid_opc == OPC_W'(OPC_RTYPE)) ||
                   (ifid_opc == OPC_W'(OPC_SW))    ||
                   (ifid_opc == OPC_W'(OPC_BEQ))   ||
                   (ifid_opc == OPC_W'(OPC_BNE));

  // $zero is never a real dependency, so a load to r0 cannot cause a hazard
  assign detect = idex_mem_read && (idex_rt != '0) &&
                  ((idex_rt == ifid_rs) || (rt_used && (idex_rt == ifid_rt)));

  // Next-state and Mealy control outputs; reset forces the pass pattern
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    id_ctrl_en = 1'b1;
    ifid_flush = 1'b0;
    if (rst) begin
      state_d = RUN;
      rem_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            id_ctrl_en = 1'b0;
          end else if (detect) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            id_ctrl_en = 1'b0;
            if (STALL_CYCLES > 1) begin
              state_d = STALL;
              rem_d   = REM_LOAD;
            end
          end
        end
        STALL: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            id_ctrl_en = 1'b0;
            state_d    = RUN;
            rem_d      = '0;
          end else begin
            // The load has already left ID/EX, so detect is not consulted here
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            id_ctrl_en = 1'b0;
            rem_d      = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_d = RUN;
            end
          end
        end
      endcase
    end
  end

  // State and remaining-cycle registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign stall_inc = !rst && !pc_write;
  assign flush_inc = ifid_flush;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed bench for hazard_stall_ctrl. Four instances share one
//               stimulus stream: STALL_CYCLES=1, 3, 4 and a 2-bit-counter
//               variant. Each step names the instance it checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] ADI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mr  = 1'b0;
  logic [4:0] xrt = '0;
  logic [4:0] rs  = '0;
  logic [4:0] rt  = '0;
  logic [5:0] opc = '0;
  logic       bt  = 1'b0;

  logic        pcw  [4];
  logic        ifw  [4];
  logic        ide  [4];
  logic        flu  [4];
  logic [15:0] sc16 [3];
  logic [15:0] fc16 [3];
  logic [1:0]  sc2, fc2;

  logic [3:0]  ctrl_o [4];
  logic [15:0] sc_o   [4];
  logic [15:0] fc_o   [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         dut;
    logic [3:0] ctrl;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.STALL_CYCLES(1)) u_d0 (
    .clk(clk), .rst(rst), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_opc(opc), .branch_taken(bt), .pc_write(pcw[0]),
    .ifid_write(ifw[0]), .id_ctrl_en(ide[0]), .ifid_flush(flu[0]),
    .stall_count(sc16[0]), .flush_count(fc16[0]));

  hazard_stall_ctrl #(.STALL_CYCLES(3)) u_d1 (
    .clk(clk), .rst(rst), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_opc(opc), .branch_taken(bt), .pc_write(pcw[1]),
    .ifid_write(ifw[1]), .id_ctrl_en(ide[1]), .ifid_flush(flu[1]),
    .stall_count(sc16[1]), .flush_count(fc16[1]));

  hazard_stall_ctrl #(.STALL_CYCLES(4)) u_d2 (
    .clk(clk), .rst(rst), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_opc(opc), .branch_taken(bt), .pc_write(pcw[2]),
    .ifid_write(ifw[2]), .id_ctrl_en(ide[2]), .ifid_flush(flu[2]),
    .stall_count(sc16[2]), .flush_count(fc16[2]));

  hazard_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(2)) u_d3 (
    .clk(clk), .rst(rst), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_opc(opc), .branch_taken(bt), .pc_write(pcw[3]),
    .ifid_write(ifw[3]), .id_ctrl_en(ide[3]), .ifid_flush(flu[3]),
    .stall_count(sc2), .flush_count(fc2));

  // Collect per-instance observations as {pc_write, ifid_write, id_ctrl_en, ifid_flush}
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ctrl_o[k] = {pcw[k], ifw[k], ide[k], flu[k]};
    end
    for (int k = 0; k < 3; k++) begin
      sc_o[k] = sc16[k];
      fc_o[k] = fc16[k];
    end
    sc_o[3] = {14'd0, sc2};
    fc_o[3] = {14'd0, fc2};
  end

  task automatic check_pending();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (ctrl_o[e.dut] === e.ctrl) else begin
        errors++;
        $error("FAIL %s d%0d ctrl observed=%b expected=%b", e.tag, e.dut, ctrl_o[e.dut], e.ctrl);
      end
      if (e.sc >= 0) begin
        checks++;
        assert (sc_o[e.dut] === 16'(e.sc)) else begin
          errors++;
          $error("FAIL %s d%0d stall_count observed=%0d expected=%0d", e.tag, e.dut, sc_o[e.dut], e.sc);
        end
      end
      if (e.fc >= 0) begin
        checks++;
        assert (fc_o[e.dut] === 16'(e.fc)) else begin
          errors++;
          $error("FAIL %s d%0d flush_count observed=%0d expected=%0d", e.tag, e.dut, fc_o[e.dut], e.fc);
        end
      end
    end
  endtask

  // One cycle: drive at negedge, queue expectation, compare shortly after
  task automatic step(input logic r, input logic m, input logic [4:0] a_xrt,
                      input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic [5:0] a_opc, input logic b, input string tag,
                      input int d, input logic [3:0] ctrl, input int sc, input int fc);
    @(negedge clk);
    rst = r; mr = m; xrt = a_xrt; rs = a_rs; rt = a_rt; opc = a_opc; bt = b;
    sb.push_back('{tag, d, ctrl, sc, fc});
    #2;
    check_pending();
  endtask

  initial begin
    // Reset dominates hazard and branch inputs
    step(1, 1, 5'd8, 5'd8, 5'd0, RT, 1, "reset", 0, 4'b1110, 0, 0);

    // Single-cycle load-use stall
    step(0, 1, 5'd8, 5'd8, 5'd3, RT, 0, "lu_stall", 0, 4'b0000, 0, 0);
    step(0, 0, 5'd8, 5'd8, 5'd3, RT, 0, "lu_after", 0, 4'b1110, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "lu_idle", 0, 4'b1110, 1, 0);

    // $zero excluded; I-type rt is not a source; SW rt is
    step(0, 1, 5'd0, 5'd0, 5'd0, RT, 0, "zero_reg", 0, 4'b1110, 1, 0);
    step(0, 1, 5'd9, 5'd1, 5'd9, ADI, 0, "addi_rt", 0, 4'b1110, 1, 0);
    step(0, 1, 5'd9, 5'd1, 5'd9, SW, 0, "sw_rt", 0, 4'b0000, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "sw_after", 0, 4'b1110, 2, 0);

    // Flush beats a simultaneous hazard
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 1, "flush_prio", 0, 4'b1101, 2, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "flush_after", 0, 4'b1110, 2, 1);

    // Three-cycle stall instance
    step(1, 0, 5'd0, 5'd0, 5'd0, RT, 0, "rst_d1", 1, 4'b1110, -1, -1);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "c9", 1, 4'b1110, 0, 0);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "c10", 1, 4'b0000, 0, 0);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "c11", 1, 4'b0000, 1, 0);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "c12", 1, 4'b0000, 2, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "c13", 1, 4'b1110, 3, 0);
    // Branch on the second stall cycle ends the stall
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "br_s1", 1, 4'b0000, 3, 0);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 1, "br_s2", 1, 4'b1101, 4, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "br_run", 1, 4'b1110, 4, 1);
    // Hazard held across the end of a stall re-stalls immediately
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "rh1", 1, 4'b0000, 4, 1);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "rh2", 1, 4'b0000, 5, 1);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "rh3", 1, 4'b0000, 6, 1);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "rh_new", 1, 4'b0000, 7, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "rh_new2", 1, 4'b0000, 8, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "rh_new3", 1, 4'b0000, 9, 1);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "rh_pass", 1, 4'b1110, 10, 1);

    // Reset in the middle of a four-cycle stall
    step(1, 0, 5'd0, 5'd0, 5'd0, RT, 0, "rst_d2", 2, 4'b1110, -1, -1);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "d2_idle", 2, 4'b1110, 0, 0);
    step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "d2_s1", 2, 4'b0000, 0, 0);
    step(1, 1, 5'd8, 5'd8, 5'd0, RT, 0, "d2_rst", 2, 4'b1110, 1, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "d2_run", 2, 4'b1110, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "d2_run2", 2, 4'b1110, 0, 0);

    // 2-bit counter saturates at 3
    step(1, 0, 5'd0, 5'd0, 5'd0, RT, 0, "rst_d3", 3, 4'b1110, -1, -1);
    step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "d3_idle", 3, 4'b1110, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 5'd8, 5'd8, 5'd0, RT, 0, "sat_haz", 3, 4'b0000, (i - 1 > 3) ? 3 : i - 1, 0);
      step(0, 0, 5'd0, 5'd0, 5'd0, RT, 0, "sat_pass", 3, 4'b1110, (i > 3) ? 3 : i, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire
